// File: rtl/logic_unit_pkg.sv
// Shared opcode encoding for the pipelined bitwise logic unit.
package logic_unit_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NOT  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_ACC  = 3'd7
  } logic_op_e;

endpackage

// File: rtl/logic_unit_pipe_op.sv
// Combinational opcode evaluator placed between the two pipe stages.
module logic_op_comb
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic_op_e        op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    unique case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NOT:  y = ~a;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      OP_ACC:  y = acc ^ a;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready bitwise logic unit with XOR accumulator.
// Optional zero flag output enabled by LOGIC_UNIT_ZERO_FLAG_EN.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             acc_clr,
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
  output logic             out_zero,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y
);

  logic             s1_valid_q;
  logic_op_e        s1_op_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_y_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] acc_base;
  logic [WIDTH-1:0] y_d;
  logic             s1_en;
  logic             s2_en;
  logic             xfer;

  assign s2_en    = !out_valid_q || out_ready;
  assign s1_en    = !s1_valid_q || s2_en;
  assign in_ready = s1_en;
  assign xfer     = s1_valid_q && s2_en;

  // A clear in the transfer cycle zeroes the base the ACC op sees.
  assign acc_base = acc_clr ? '0 : acc_q;

  logic_op_comb #(
    .WIDTH(WIDTH)
  ) u_op (
    .op (s1_op_q),
    .a  (s1_a_q),
    .b  (s1_b_q),
    .acc(acc_base),
    .y  (y_d)
  );

  always_comb begin
    acc_d = acc_q;
    if (xfer && s1_op_q == OP_ACC) begin
      acc_d = y_d;
    end else if (acc_clr) begin
      acc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= OP_AND;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
    end else if (s1_en) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_op_q <= logic_op_e'(in_op);
        s1_a_q  <= in_a;
        s1_b_q  <= in_b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
    end else if (s2_en) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_y_q <= y_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

`ifdef LOGIC_UNIT_ZERO_FLAG_EN
  logic zero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
    end else if (xfer) begin
      zero_q <= ~|y_d;
    end
  end

  assign out_zero = zero_q;
`endif

  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed and randomized checks for logic_unit_pipe at WIDTH=8.
module tb_logic_unit_pipe;

  localparam int W = 8;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         acc_clr;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_y;
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
  logic         out_zero;
`endif

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int rx     = 0;
  int pushed = 0;
  bit mon_en = 1'b0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;

  logic_unit_pipe #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_a     (in_a),
    .in_b     (in_b),
    .acc_clr  (acc_clr),
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    .out_zero (out_zero),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_y    (out_y)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [W-1:0] ref_y(input logic [2:0] op,
                                         input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic [W-1:0] acc);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return ~a;
      3'd3:    return ~(a & b);
      3'd4:    return ~(a | b);
      3'd5:    return a ^ b;
      3'd6:    return ~(a ^ b);
      default: return acc ^ a;
    endcase
  endfunction

  // Scoreboard: a beat leaves at the next rising edge when valid&&ready.
  always @(negedge clk) begin
    if (mon_en && rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_out: got %0h expected none", out_y);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_y", out_y, mon_e);
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
        chk("out_zero", out_zero, mon_e == '0);
`endif
        rx++;
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] e,
                      input bit track);
    int n = 0;
    bit done = 1'b0;
    in_valid = 1'b1;
    in_op = op;
    in_a = a;
    in_b = b;
    while (!done && n < 100) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1'b1;
        if (track) begin
          exp_q.push_back(e);
          pushed++;
        end
      end
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      fails++;
      $display("FAIL send_timeout: got no in_ready expected in_ready=1");
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic clr_pulse();
    acc_clr = 1'b1;
    @(posedge clk);
    #1;
    acc_clr = 1'b0;
  endtask

  vec_t tbl[10];

  initial begin
    int t0;
    int k;
    int n;
    int sent;
    bit took;
    logic [W-1:0] m_acc;
    logic [W-1:0] e;

    tbl[0] = '{3'd0, 8'hC3, 8'hA5, 8'h81};
    tbl[1] = '{3'd1, 8'hC3, 8'hA5, 8'hE7};
    tbl[2] = '{3'd2, 8'hC3, 8'hA5, 8'h3C};
    tbl[3] = '{3'd3, 8'hC3, 8'hA5, 8'h7E};
    tbl[4] = '{3'd4, 8'hC3, 8'hA5, 8'h18};
    tbl[5] = '{3'd5, 8'hC3, 8'hA5, 8'h66};
    tbl[6] = '{3'd6, 8'hC3, 8'hA5, 8'h99};
    tbl[7] = '{3'd7, 8'h0F, 8'h00, 8'h0F};
    tbl[8] = '{3'd7, 8'hF0, 8'h00, 8'hFF};
    tbl[9] = '{3'd7, 8'hFF, 8'h00, 8'h00};

    rst_n = 1'b0;
    in_valid = 1'b0;
    acc_clr = 1'b0;
    out_ready = 1'b1;
    in_op = '0;
    in_a = '0;
    in_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_in_ready", in_ready, 1);
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    chk("rst_out_zero", out_zero, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    clr_pulse();
    t0 = cyc;
    for (int i = 0; i < 10; i++) begin
      send(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].y, 1'b1);
    end
    chk("throughput_cycles", cyc - t0, 10);
    drain();

    send(3'd0, 8'hFF, 8'h0F, 8'h0F, 1'b1);
    chk("lat_1edge_valid", out_valid, 0);
    @(posedge clk);
    #1;
    chk("lat_2edge_valid", out_valid, 1);
    chk("lat_2edge_y", out_y, 8'h0F);
    drain();

    out_ready = 1'b0;
    k = 0;
    in_valid = 1'b1;
    in_op = 3'd5;
    in_b = 8'h01;
    in_a = 8'h10;
    repeat (6) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(in_a ^ in_b);
        pushed++;
        k++;
      end
      @(posedge clk);
      #1;
      in_a = 8'(8'h10 + k);
    end
    chk("cap_accepts", k, 2);
    chk("cap_in_ready", in_ready, 0);
    chk("cap_hold_valid", out_valid, 1);
    chk("cap_hold_y", out_y, 8'h11);
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("ready_follows_out_ready", in_ready, 1);
    drain();

    clr_pulse();
    send(3'd7, 8'hAA, 8'h00, 8'hAA, 1'b1);
    drain();
    send(3'd7, 8'h55, 8'h00, 8'h55, 1'b1);
    clr_pulse();
    send(3'd7, 8'h00, 8'h00, 8'h55, 1'b1);
    drain();

    send(3'd7, 8'h80, 8'h00, 8'hD5, 1'b1);
    drain();
    out_ready = 1'b0;
    send(3'd1, 8'h01, 8'h02, 8'h03, 1'b0);
    send(3'd1, 8'h04, 8'h08, 8'h0C, 1'b0);
    chk("full_out_valid", out_valid, 1);
    chk("full_in_ready", in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_y", out_y, 0);
    chk("midrst_in_ready", in_ready, 1);
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    chk("midrst_out_zero", out_zero, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(3'd7, 8'h01, 8'h00, 8'h01, 1'b1);
    drain();

    clr_pulse();
    m_acc = '0;
    sent = 0;
    n = 0;
    took = 1'b0;
    while (sent < 1000 && n < 20000) begin
      if (took) in_valid = 1'b0;
      took = 1'b0;
      out_ready = ($urandom % 4) != 0;
      if (!in_valid && ($urandom % 3) != 0) begin
        in_valid = 1'b1;
        in_op = 3'($urandom);
        in_a = 8'($urandom);
        in_b = 8'($urandom);
      end
      @(negedge clk);
      if (in_valid && in_ready) begin
        e = ref_y(in_op, in_a, in_b, m_acc);
        if (in_op == 3'd7) m_acc = e;
        exp_q.push_back(e);
        pushed++;
        sent++;
        took = 1'b1;
      end
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("rand_beats_sent", sent, 1000);
    drain();
    chk("rx_total", rx, pushed);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
